mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between an instruction-fetch
//             port and a data port. Data has priority, and a starve counter
//             bounds how long fetch can wait.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] c_lat = 3'(MEM_LAT);

    state_t      state_q,     state_d;
    logic [1:0]  starve_q,    starve_d;
    logic        owner_q,     owner_d;
    logic        we_q,        we_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic        mem_en_q,    mem_en_d;
    logic        mem_we_q,    mem_we_d;
    logic [29:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;
    logic        if_ready_q,  if_ready_d;
    logic        d_ready_q,   d_ready_d;

    logic        w_grant_data;
    logic        w_unused_addr_lsbs;

    // Fetch only overtakes a pending data request after two consecutive data wins.
    assign w_grant_data       = d_req && !(if_req && (starve_q == 2'd2));
    assign w_unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req && w_grant_data) begin
                    starve_d = (starve_q == 2'd2) ? 2'd2 : starve_q + 2'd1;
                end else begin
                    starve_d = 2'd0;
                end
                if (if_req || d_req) begin
                    owner_d     = w_grant_data;
                    we_d        = w_grant_data && d_we;
                    mem_addr_d  = w_grant_data ? d_addr[31:2] : if_addr[31:2];
                    mem_wdata_d = w_grant_data ? d_wdata : 32'h0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = w_grant_data && d_we;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = c_lat;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RESP;
                    if (owner_q) begin
                        d_ready_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= 2'd0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 30'h0;
            mem_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign stall     = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule
`default_nettype wire
